// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch PC generator, imem req/ack, IR/PC queue to decode.
// Define FETCH_BYPASS_EN to let an empty-queue ack reach ir in the same cycle.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_INC   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [15:0] ir_pc
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [15:0]   INC  = 16'(PC_INC);
  localparam logic [AW-1:0] ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [15:0]   hold_addr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   ir_mem [DEPTH];
  logic [15:0]   pc_mem [DEPTH];

  logic push;
  logic pop;
  logic byp;
  logic wr_en;
  logic rd_adv;
  logic space;

  assign imem_req  = (state == REQ) || (state == DROP);
  // A dropped request must keep its old address while fetch_pc moves on.
  assign imem_addr = (state == DROP) ? hold_addr : fetch_pc;

  assign push = imem_ack && (state == REQ) && !redirect;

`ifdef FETCH_BYPASS_EN
  assign byp = push && (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign ir_valid = (count != '0) || byp;
  assign pop      = ir_valid && ir_ready && !redirect;
  assign wr_en    = push && !(byp && ir_ready);
  assign rd_adv   = pop && !byp;
  assign count_nx = redirect ? '0
                  : count + CW'(wr_en) - CW'(rd_adv);
  assign space    = count_nx < FULL;

  always_comb begin
    ir    = 16'h0000;
    ir_pc = 16'h0000;
    unique case (1'b1)
      byp: begin
        ir    = imem_rdata;
        ir_pc = imem_addr;
      end
      (count != '0): begin
        ir    = ir_mem[rd_ptr];
        ir_pc = pc_mem[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      ir_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr] <= fetch_pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      count <= count_nx;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + ONE;
        if (rd_adv) rd_ptr <= rd_ptr + ONE;
      end
      unique case (state)
        IDLE: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (space)    state    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc <= redirect ? redirect_pc
                                 : fetch_pc + INC;
            state    <= space ? REQ : IDLE;
          end else if (redirect) begin
            fetch_pc  <= redirect_pc;
            hold_addr <= fetch_pc;
            state     <= DROP;
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack) state    <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
